// File: rtl/vga_tile_pkg.sv
// Shared types and default sizes for the VGA tile-row prefetcher.
// The optional ack watchdog is enabled with VGA_TILE_FETCH_TIMEOUT_EN.
package vga_tile_pkg;

  localparam int DEF_ADDR_W    = 16;
  localparam int DEF_DATA_W    = 16;
  localparam int DEF_PIC_W     = 9;
  localparam int DEF_X_W       = 5;
  localparam int DEF_Y_W       = 4;
  localparam int DEF_TILE_COLS = 20;
  localparam int DEF_TIMEOUT   = 255;

  // Two banks (display/back), so one select bit.
  localparam int BANK_SEL_W = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/tile_line_buffer.sv
// Two-bank tile-number line buffer: one write port, one registered read port.
// Contents are never cleared; callers mask reads that are not yet valid.
module tile_line_buffer
  import vga_tile_pkg::*;
#(
  parameter int PIC_W     = DEF_PIC_W,
  parameter int X_W       = DEF_X_W,
  parameter int TILE_COLS = DEF_TILE_COLS
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [BANK_SEL_W-1:0] wr_bank,
  input  logic [X_W-1:0]        wr_addr,
  input  logic [PIC_W-1:0]      wr_data,
  input  logic [BANK_SEL_W-1:0] rd_bank,
  input  logic [X_W-1:0]        rd_addr,
  output logic [PIC_W-1:0]      rd_data
);

  localparam logic [X_W:0] COLS_EXT = (X_W + 1)'(TILE_COLS);

  logic                  wr_in_range;
  logic                  rd_in_range;
  logic [BANK_SEL_W-1:0] rd_bank_q;

  assign wr_in_range = ({1'b0, wr_addr} < COLS_EXT);
  assign rd_in_range = ({1'b0, rd_addr} < COLS_EXT);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bank
      logic [PIC_W-1:0] mem [TILE_COLS];
      logic [PIC_W-1:0] rd_q;

      // Write port: only the addressed bank takes the word.
      always_ff @(posedge clk) begin
        if (wr_en && wr_in_range && (wr_bank == BANK_SEL_W'(gi))) begin
          mem[wr_addr] <= wr_data;
        end
      end

      // Registered read of every bank; out-of-range addresses hold the last word.
      always_ff @(posedge clk) begin
        if (rd_in_range) begin
          rd_q <= mem[rd_addr];
        end
      end
    end
  endgenerate

  // Remember which bank was selected so the output mux matches the read cycle.
  always_ff @(posedge clk) begin
    rd_bank_q <= rd_bank;
  end

  assign rd_data = (rd_bank_q == BANK_SEL_W'(1)) ? g_bank[1].rd_q : g_bank[0].rd_q;

endmodule

// File: rtl/vga_tile_fetch.sv
// Double-buffered tile-row prefetcher: fetches TILE_COLS tile numbers over a
// req/ack port into a back bank, then swaps it in for the pixel-side reader.
// Define VGA_TILE_FETCH_TIMEOUT_EN to add the ack watchdog and err_timeout.
module vga_tile_fetch
  import vga_tile_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int PIC_W     = DEF_PIC_W,
  parameter int X_W       = DEF_X_W,
  parameter int Y_W       = DEF_Y_W,
  parameter int TILE_COLS = DEF_TILE_COLS,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              row_start,
  input  logic [Y_W-1:0]    row_y,
  input  logic [ADDR_W-1:0] start_address,
  input  logic [ADDR_W-1:0] row_length,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [X_W-1:0]    rd_x,
  output logic [PIC_W-1:0]  pic_num,
  output logic              row_ready,
  output logic              busy,
  output logic              err_overrun
`ifdef VGA_TILE_FETCH_TIMEOUT_EN
  ,
  output logic              err_timeout
`endif
);

  localparam logic [X_W-1:0] LAST_COL = X_W'(TILE_COLS - 1);
  localparam logic [X_W:0]   COLS_EXT = (X_W + 1)'(TILE_COLS);

  fetch_state_t          state_q, state_d;
  logic [ADDR_W-1:0]     base_q, base_d;
  logic [X_W-1:0]        col_q, col_d;
  logic [BANK_SEL_W-1:0] disp_bank_q, disp_bank_d;
  logic                  valid_q, valid_d;
  logic                  row_ready_q, row_ready_d;
  logic                  err_overrun_q, err_overrun_d;
  logic                  rd_ok_q, rd_ok_d;

  logic                  buf_we;
  logic [PIC_W-1:0]      buf_rd_data;
  logic [ADDR_W-1:0]     row_off;

  // The low ADDR_W bits of a product depend only on the low ADDR_W bits of
  // its operands, so an ADDR_W-wide multiply equals the truncated full product.
  assign row_off = ADDR_W'(row_y) * row_length;

  // Upper data bits beyond the tile number are deliberately dropped.
  logic unused_data_bits;
  assign unused_data_bits = ^mem_data;

`ifdef VGA_TILE_FETCH_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              err_timeout_q, err_timeout_d;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT;
`endif

  // Next-state logic for the fetch FSM, bank swap and sticky error flags.
  always_comb begin
    state_d       = state_q;
    base_d        = base_q;
    col_d         = col_q;
    disp_bank_d   = disp_bank_q;
    valid_d       = valid_q;
    row_ready_d   = 1'b0;
    err_overrun_d = err_overrun_q;
    buf_we        = 1'b0;
`ifdef VGA_TILE_FETCH_TIMEOUT_EN
    wait_d        = wait_q;
    err_timeout_d = err_timeout_q;
`endif

    // A request while a fetch is in flight is dropped and flagged.
    if (row_start && (state_q != ST_IDLE)) begin
      err_overrun_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (row_start) begin
          base_d  = start_address + row_off;
          col_d   = '0;
          state_d = ST_REQ;
`ifdef VGA_TILE_FETCH_TIMEOUT_EN
          wait_d  = '0;
`endif
        end
      end

      ST_REQ: begin
        if (mem_ack) begin
          buf_we = 1'b1;
`ifdef VGA_TILE_FETCH_TIMEOUT_EN
          wait_d = '0;
`endif
          if (col_q == LAST_COL) begin
            state_d = ST_DONE;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
`ifdef VGA_TILE_FETCH_TIMEOUT_EN
        else if ((wait_q + 1'b1) == WAIT_W'(TIMEOUT)) begin
          // Memory stopped answering: abandon the row without swapping.
          state_d       = ST_IDLE;
          err_timeout_d = 1'b1;
          wait_d        = '0;
        end else begin
          wait_d = wait_q + 1'b1;
        end
`endif
      end

      ST_DONE: begin
        disp_bank_d = ~disp_bank_q;
        valid_d     = 1'b1;
        row_ready_d = 1'b1;
        state_d     = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Read-side mask: blank output until a row is valid or when past the row end.
  assign rd_ok_d = valid_q && ({1'b0, rd_x} < COLS_EXT);

  // State register with synchronous reset; the partial back bank is abandoned.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      base_q        <= '0;
      col_q         <= '0;
      disp_bank_q   <= '0;
      valid_q       <= 1'b0;
      row_ready_q   <= 1'b0;
      err_overrun_q <= 1'b0;
      rd_ok_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      base_q        <= base_d;
      col_q         <= col_d;
      disp_bank_q   <= disp_bank_d;
      valid_q       <= valid_d;
      row_ready_q   <= row_ready_d;
      err_overrun_q <= err_overrun_d;
      rd_ok_q       <= rd_ok_d;
    end
  end

`ifdef VGA_TILE_FETCH_TIMEOUT_EN
  // Watchdog counter and its sticky error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_q        <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      wait_q        <= wait_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign err_timeout = err_timeout_q;
`endif

  // Reads always use the display bank as it stands this cycle, so a read in
  // the swap cycle still sees the old row.
  tile_line_buffer #(
    .PIC_W     (PIC_W),
    .X_W       (X_W),
    .TILE_COLS (TILE_COLS)
  ) u_line_buffer (
    .clk     (clk),
    .wr_en   (buf_we),
    .wr_bank (~disp_bank_q),
    .wr_addr (col_q),
    .wr_data (mem_data[PIC_W-1:0]),
    .rd_bank (disp_bank_q),
    .rd_addr (rd_x),
    .rd_data (buf_rd_data)
  );

  assign mem_req     = (state_q == ST_REQ);
  assign mem_addr    = base_q + ADDR_W'(col_q);
  assign busy        = (state_q != ST_IDLE);
  assign row_ready   = row_ready_q;
  assign err_overrun = err_overrun_q;
  assign pic_num     = rd_ok_q ? buf_rd_data : '0;

endmodule

// File: doc/vga_tile_fetch.md
Name: vga_tile_fetch

Overview:
- Parametrised, double-buffered tile-row prefetcher for the VGA path.
- On a row request it computes `base = start_address + row_y*row_length`, then reads TILE_COLS tile indices from memory using a req/ack handshake.
- Indices are stored in a back bank, which becomes the display bank when the row completes.
- The pixel side reads tile numbers by column with fixed 1-cycle latency and never stalls.

Parameters:
- ADDR_W, 16, memory address width
- DATA_W, 16, memory data width
- PIC_W, 9, tile/picture number width; must be <= DATA_W
- X_W, 5, column index width
- Y_W, 4, row index width
- TILE_COLS, 20, tiles per row; must be <= 2**X_W
- TIMEOUT, 255, ack watchdog limit in cycles (optional feature only)

Ports:
- clk  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- row_start  in  1  one-cycle pulse: begin fetch of row row_y
- row_y  in  Y_W  tile row to fetch; sampled with row_start
- start_address  in  ADDR_W  top-left tile address; sampled with row_start
- row_length  in  ADDR_W  tiles per memory row (stride); sampled with row_start
- mem_req  out  1  memory read request
- mem_addr  out  ADDR_W  read address; stable while mem_req=1
- mem_ack  in  1  mem_data valid this cycle; completes the request
- mem_data  in  DATA_W  read data
- rd_x  in  X_W  display column
- pic_num  out  PIC_W  tile number for rd_x, registered
- row_ready  out  1  one-cycle pulse: banks swapped
- busy  out  1  fetch in progress
- err_overrun  out  1  sticky: row_start arrived while busy

Behaviour:
- Reset values: mem_req=0, mem_addr=0, pic_num=0, row_ready=0, busy=0, err_overrun=0, FSM=IDLE, display bank=0, valid=0.
- Buffer RAM contents are not cleared by reset. While valid=0, pic_num reads 0.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - On row_start: latch `base = start_address + row_y*row_length`, truncated mod 2**ADDR_W (product computed at full width, then truncated). Set col=0 and go to REQ.
  - busy=1 from the next cycle.
- REQ:
  - mem_req=1, mem_addr = base + col (mod 2**ADDR_W).
  - Ack may arrive in the first REQ cycle or any later cycle.
  - On mem_ack: write mem_data[PIC_W-1:0] to back_bank[col]; upper bits are ignored.
  - If col==TILE_COLS-1, go to DONE and drop mem_req in that cycle. Otherwise col++; mem_req stays high with the new address next cycle (back-to-back reads allowed).
- DONE (one cycle):
  - Swap banks, set valid=1, pulse row_ready=1, clear busy, return to IDLE.
  - A row_start arriving in the DONE cycle is treated as overrun.
- Overrun: row_start while busy (REQ or DONE) is ignored, the current fetch continues, and err_overrun is set. It stays set until reset.
- mem_ack while mem_req=0 is ignored.
- Read path:
  - pic_num <= valid ? disp_bank[rd_x] : 0, updated every cycle; latency 1.
  - If rd_x >= TILE_COLS, pic_num <= 0.
  - Reads in the swap cycle return the old bank; the new bank is visible from the next read.
- Reset mid-fetch: FSM returns to IDLE and mem_req drops in the next cycle. The partial back bank is discarded (no swap). The display bank is invalidated (valid=0).
- Simultaneous reset and row_start: reset wins; the request is lost.

Optional Feature:
- Macro: VGA_TILE_FETCH_TIMEOUT_EN.
- Defined:
  - A wait counter clears on each ack and increments every REQ cycle without ack.
  - When it reaches TIMEOUT: abort the fetch, mem_req=0, no bank swap, return to IDLE.
  - Adds output err_timeout (1 bit, sticky, reset 0), which is set on abort.
- Not defined: no counter and no err_timeout port; REQ waits indefinitely.

Decomposition:
- Package vga_tile_pkg:
  - FSM state enum (IDLE/REQ/DONE).
  - Default width constants (ADDR_W, PIC_W, X_W, Y_W, TILE_COLS).
  - A localparam for the bank-select width.
- Sub-module tile_line_buffer: two banks of TILE_COLS x PIC_W, one write port (bank select, addr, data, we) and one registered read port (bank select, addr).
- Swap, valid and out-of-range masking stay in vga_tile_fetch.

Test Plan:
1. Reset, then row_start with start_address=0x0100, row_length=20, row_y=3, ack every cycle → mem_addr runs 0x013C..0x014F; row_ready pulses once; rd_x=5 returns mem_data[8:0] of 0x0141 one cycle later.
2. Ack delayed 3 cycles per request → mem_addr held stable while mem_req=1; 20 writes total; a single row_ready pulse.
3. row_start mid-fetch → ignored, err_overrun=1, addresses continue unchanged; reset clears err_overrun.
4. Reset asserted at col=7, then rd_x=0 → mem_req=0 next cycle, no row_ready, pic_num=0; a new fetch completes normally afterwards.
5. Address wrap: start_address=0xFFF8, row_y=0 → mem_addr 0xFFF8..0xFFFF then 0x0000..0x000B; rd_x=25 → pic_num=0.
6. With VGA_TILE_FETCH_TIMEOUT_EN and TIMEOUT=8, no ack → mem_req drops after 8 cycles, err_timeout=1, display bank and valid unchanged.
